// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encodings, register-address width and decoder opcode classes
package hazard_ctrl_pkg;
  localparam int REG_W = 3;
  typedef logic [REG_W-1:0] reg_addr_t;
  typedef logic [1:0] need_t;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;
  // Opcode classes the decoder maps onto id_uses_rs / id_uses_rt / id_br_rs
  typedef enum logic [2:0] {
    OPC_ALU_RR  = 3'd0,
    OPC_ALU_RI  = 3'd1,
    OPC_LOAD    = 3'd2,
    OPC_STORE   = 3'd3,
    OPC_BRANCH  = 3'd4,
    OPC_JUMP    = 3'd5,
    OPC_JUMP_RG = 3'd6,
    OPC_OTHER   = 3'd7
  } opc_class_t;
  typedef struct packed {
    logic uses_rs;
    logic uses_rt;
    logic br_rs;
  } opc_use_t;
  function automatic opc_use_t opc_use(opc_class_t c);
    opc_use_t u;
    u.uses_rs = (c != OPC_JUMP) && (c != OPC_OTHER);
    u.uses_rt = (c == OPC_ALU_RR) || (c == OPC_STORE);
    u.br_rs   = (c == OPC_BRANCH) || (c == OPC_JUMP_RG);
    return u;
  endfunction
endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect: combinational stall need (0..2 cycles) and raw EX/MEM-to-decode Rs forward
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic      id_valid,
  input  reg_addr_t id_rs_addr,
  input  reg_addr_t id_rt_addr,
  input  logic      id_uses_rs,
  input  logic      id_uses_rt,
  input  logic      id_br_rs,
  input  logic      ex_regwrite,
  input  logic      ex_memtoreg,
  input  reg_addr_t ex_rd_addr,
  input  logic      mem_regwrite,
  input  logic      mem_memtoreg,
  input  reg_addr_t mem_rd_addr,
  output need_t     need,
  output logic      fwd_raw
);
  logic ex_rs, ex_rt, mem_rs, br_ex, br_ex_ld, br_mem_ld, ld_use;
  always_comb begin
    ex_rs     = ex_regwrite & (ex_rd_addr == id_rs_addr);
    ex_rt     = ex_regwrite & (ex_rd_addr == id_rt_addr);
    mem_rs    = mem_regwrite & (mem_rd_addr == id_rs_addr);
    br_ex     = id_br_rs & ex_rs;
    br_ex_ld  = br_ex & ex_memtoreg;
    br_mem_ld = id_br_rs & mem_rs & mem_memtoreg;
    ld_use    = ex_memtoreg & ((id_uses_rs & ex_rs) | (id_uses_rt & ex_rt));
    need      = ~id_valid ? 2'd0 : br_ex_ld ? 2'd2 : (br_ex | br_mem_ld | ld_use) ? 2'd1 : 2'd0;
    fwd_raw   = id_br_rs & mem_rs & ~mem_memtoreg;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage pipeline sequencer (hazard stalls, bubbles, branch flush, dmem freeze, halt)
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs_addr,
  input  logic [2:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_br_rs,
  input  logic             id_branch,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [2:0]       ex_rd_addr,
  input  logic             mem_regwrite,
  input  logic             mem_memtoreg,
  input  logic [2:0]       mem_rd_addr,
  input  logic             dmem_busy,
  input  logic             mem_halt,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             fwd_rs_dec,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t state;
  logic [1:0] cnt;
  need_t need;
  logic fwd_raw, halt_st, run_st, freeze, hz;
  hazard_detect u_detect (
    .id_valid    (id_valid),
    .id_rs_addr  (id_rs_addr),
    .id_rt_addr  (id_rt_addr),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_br_rs    (id_br_rs),
    .ex_regwrite (ex_regwrite),
    .ex_memtoreg (ex_memtoreg),
    .ex_rd_addr  (ex_rd_addr),
    .mem_regwrite(mem_regwrite),
    .mem_memtoreg(mem_memtoreg),
    .mem_rd_addr (mem_rd_addr),
    .need        (need),
    .fwd_raw     (fwd_raw)
  );
  always_comb begin
    halt_st     = state == ST_HALT;
    run_st      = state == ST_RUN;
    freeze      = halt_st | dmem_busy;
    hz          = (state == ST_STALL) | (run_st & (need != 2'd0));
    pipe_freeze = ~rst & freeze;
    pc_stall    = ~rst & (freeze | hz);
    ifid_stall  = pc_stall;
    idex_bubble = ~rst & ~freeze & hz;
    ifid_flush  = ~rst & ~freeze & run_st & (need == 2'd0) & id_branch & id_valid;
    fwd_rs_dec  = ~rst & ~halt_st & (need == 2'd0) & fwd_raw;
  end
  // cnt holds the STALL cycles still owed after the RUN cycle that detected the hazard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= 2'd0;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (pc_stall & ~halt_st & (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (~halt_st & mem_halt & ~dmem_busy) begin
        state  <= ST_HALT;
        halted <= 1'b1;
      end else if (~freeze & run_st & (need != 2'd0)) begin
        cnt   <= need - 2'd1;
        state <= (need == 2'd2) ? ST_STALL : ST_RUN;
      end else if (~freeze & (state == ST_STALL)) begin
        cnt   <= (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        state <= (cnt > 2'd1) ? ST_STALL : ST_RUN;
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed pipeline scenarios plus randomized traffic against a cycle-level reference model
module tb_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid, id_uses_rs, id_uses_rt, id_br_rs, id_branch;
  logic [2:0] id_rs_addr, id_rt_addr, ex_rd_addr, mem_rd_addr;
  logic ex_regwrite, ex_memtoreg, mem_regwrite, mem_memtoreg, dmem_busy, mem_halt;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, fwd_rs_dec, halted;
  logic [15:0] stall_cnt;
  logic s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_bubble, s_pipe_freeze, s_fwd_rs_dec, s_halted;
  logic [3:0] s_stall_cnt;
  int tests = 0, fails = 0;
  int m_left = 0, m_cnt = 0;
  bit m_halt = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_br_rs(id_br_rs), .id_branch(id_branch),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_rd_addr(ex_rd_addr),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_rd_addr(mem_rd_addr),
    .dmem_busy(dmem_busy), .mem_halt(mem_halt), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .fwd_rs_dec(fwd_rs_dec), .halted(halted), .stall_cnt(stall_cnt));
  hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_br_rs(id_br_rs), .id_branch(id_branch),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_rd_addr(ex_rd_addr),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_rd_addr(mem_rd_addr),
    .dmem_busy(dmem_busy), .mem_halt(mem_halt), .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .pipe_freeze(s_pipe_freeze),
    .fwd_rs_dec(s_fwd_rs_dec), .halted(s_halted), .stall_cnt(s_stall_cnt));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int need_f();
    int n = 0;
    if (!id_valid) return 0;
    if (id_br_rs && ex_regwrite && ex_rd_addr == id_rs_addr) n = ex_memtoreg ? 2 : 1;
    if (id_br_rs && mem_regwrite && mem_memtoreg && mem_rd_addr == id_rs_addr && n < 1) n = 1;
    if (ex_memtoreg && ex_regwrite && ((id_uses_rs && ex_rd_addr == id_rs_addr) ||
        (id_uses_rt && ex_rd_addr == id_rt_addr)) && n < 1) n = 1;
    return n;
  endfunction
  function automatic logic [6:0] outs();
    return {pipe_freeze, pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_rs_dec, halted};
  endfunction
  task automatic idle();
    {id_valid, id_uses_rs, id_uses_rt, id_br_rs, id_branch} = '0;
    {ex_regwrite, ex_memtoreg, mem_regwrite, mem_memtoreg, dmem_busy, mem_halt} = '0;
    {id_rs_addr, id_rt_addr, ex_rd_addr, mem_rd_addr} = '0;
  endtask
  task automatic step(string tag);
    int n;
    bit fz, st, fl, fw, pcs;
    @(negedge clk);
    #1;
    n   = need_f();
    fz  = m_halt || dmem_busy;
    st  = m_left > 0 || n > 0;
    pcs = fz || st;
    fl  = !fz && m_left == 0 && n == 0 && id_branch && id_valid;
    fw  = !m_halt && n == 0 && id_br_rs && mem_regwrite && !mem_memtoreg && mem_rd_addr == id_rs_addr;
    chk({tag, "_outs"}, outs(), {fz, pcs, pcs, !fz && st, fl, fw, m_halt});
    chk({tag, "_cnt"}, stall_cnt, m_cnt > 65535 ? 65535 : m_cnt);
    chk({tag, "_cnt4"}, s_stall_cnt, m_cnt > 15 ? 15 : m_cnt);
    @(posedge clk);
    if (pcs && !m_halt) m_cnt++;
    if (!m_halt && mem_halt && !dmem_busy) m_halt = 1;
    else if (!m_halt && !dmem_busy) begin
      if (m_left > 0) m_left--;
      else if (n > 0) m_left = n - 1;
    end
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_outs", outs(), 0);
    chk("rst_cnt", stall_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_left = 0; m_halt = 0; m_cnt = 0;
  endtask
  task automatic rnd();
    id_valid = $urandom_range(0, 7) != 0;
    id_rs_addr = 3'($urandom_range(0, 3)); id_rt_addr = 3'($urandom_range(0, 3));
    ex_rd_addr = 3'($urandom_range(0, 3)); mem_rd_addr = 3'($urandom_range(0, 3));
    {id_uses_rs, id_uses_rt, id_br_rs, id_branch} = 4'($urandom);
    {ex_regwrite, ex_memtoreg, mem_regwrite, mem_memtoreg} = 4'($urandom);
    dmem_busy = $urandom_range(0, 4) == 0;
    mem_halt = $urandom_range(0, 99) == 0;
  endtask
  initial begin
    idle();
    id_valid = 1; id_br_rs = 1; id_rs_addr = 1; ex_regwrite = 1; ex_memtoreg = 1; ex_rd_addr = 1;
    #13;
    chk("init_outs", outs(), 0);
    chk("init_cnt", stall_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    // load-use: ld r1 in ID/EX, add r2,r1,r3 in ID
    idle();
    id_valid = 1; id_rs_addr = 1; id_rt_addr = 3; id_uses_rs = 1; id_uses_rt = 1;
    ex_regwrite = 1; ex_memtoreg = 1; ex_rd_addr = 1;
    step("ldu_stall");
    ex_regwrite = 0; ex_memtoreg = 0; mem_regwrite = 1; mem_memtoreg = 1; mem_rd_addr = 1;
    step("ldu_go");
    chk("ldu_total", stall_cnt, 1);
    // ld r1 in ID/EX, beqz r1 taken in ID
    do_reset();
    idle();
    id_valid = 1; id_rs_addr = 1; id_uses_rs = 1; id_br_rs = 1; id_branch = 1;
    ex_regwrite = 1; ex_memtoreg = 1; ex_rd_addr = 1;
    step("ldbr_s1");
    chk("ldbr_state", dut.state, 1);
    ex_regwrite = 0; ex_memtoreg = 0; mem_regwrite = 1; mem_memtoreg = 1; mem_rd_addr = 1;
    step("ldbr_s2");
    mem_regwrite = 0; mem_memtoreg = 0;
    step("ldbr_flush");
    chk("ldbr_total", stall_cnt, 2);
    // add r1 in EX/MEM, bnez r1 taken: forward and flush, no stall
    idle();
    id_valid = 1; id_rs_addr = 1; id_uses_rs = 1; id_br_rs = 1; id_branch = 1;
    mem_regwrite = 1; mem_rd_addr = 1;
    step("fwd_br");
    // add r1 in ID/EX, jr r1
    idle();
    id_valid = 1; id_rs_addr = 1; id_uses_rs = 1; id_br_rs = 1; id_branch = 1;
    ex_regwrite = 1; ex_rd_addr = 1;
    step("jr_stall");
    ex_regwrite = 0; mem_regwrite = 1; mem_rd_addr = 1;
    step("jr_fwd");
    chk("jr_total", stall_cnt, 3);
    // dmem busy 3 cycles over a pending 2-cycle hazard
    do_reset();
    idle();
    id_valid = 1; id_rs_addr = 2; id_uses_rs = 1; id_br_rs = 1; id_branch = 1;
    ex_regwrite = 1; ex_memtoreg = 1; ex_rd_addr = 2; dmem_busy = 1;
    for (int i = 0; i < 3; i++) step("busy");
    dmem_busy = 0;
    step("busy_s1");
    ex_regwrite = 0; ex_memtoreg = 0; mem_regwrite = 1; mem_memtoreg = 1; mem_rd_addr = 2;
    step("busy_s2");
    mem_regwrite = 0; mem_memtoreg = 0;
    step("busy_flush");
    chk("busy_total", stall_cnt, 5);
    // halt latches and persists
    idle();
    mem_halt = 1;
    step("halt_req");
    chk("halt_next", halted, 1);
    mem_halt = 0;
    for (int i = 0; i < 6; i++) begin rnd(); step("halt_hold"); end
    // reset asserted mid-STALL
    do_reset();
    idle();
    id_valid = 1; id_rs_addr = 4; id_br_rs = 1; ex_regwrite = 1; ex_memtoreg = 1; ex_rd_addr = 4;
    step("pre_rst");
    do_reset();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd();
      if ($urandom_range(0, 199) == 0) do_reset();
      else step("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
